// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers hcount/vcount from active-high hsync/vsync/
// hblnk/vblnk, measures line/frame geometry and declares lock once
// MATCH_FRAMES consecutive frames measure identically.
// Optional: define VGA_DECODER_SYNC_CHECK_EN to measure hsync/vsync widths
// and include them in the lock criteria (otherwise widths read 0).
module vga_timing_decoder #(
  parameter int MATCH_FRAMES = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic [11:0] h_active,
  output logic [11:0] v_active,
  output logic [11:0] h_sync_w,
  output logic [11:0] v_sync_w,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state, state_nx;
  logic [3:0]    match_cnt, match_nx;
  logic [TW-1:0] to_cnt;
  logic          hblnk_q, vblnk_q;
  logic          ls, fs, hb_rise, vb_rise, timeout, line_mm, frame_mm, sync_match;
  logic          lock_err_nx;
  logic [11:0]   h_inc, v_inc, ha_new, va_new;
  logic [11:0]   prev_ht, prev_ha, prev_vt, prev_va;

  // Line start is the end of horizontal blanking; a frame start is a line
  // start that also ends vertical blanking.
  assign ls      = hblnk_q & ~hblnk_in;
  assign fs      = ls & vblnk_q & ~vblnk_in;
  assign hb_rise = ~hblnk_q & hblnk_in;
  assign vb_rise = ~vblnk_q & vblnk_in;
  assign h_inc   = hcount + 12'd1;
  assign v_inc   = vcount + 12'd1;
  // Values the measurement registers take at this edge, for the frame compare
  assign ha_new  = hb_rise ? h_inc : h_active;
  assign va_new  = vb_rise ? v_inc : v_active;

  assign timeout  = ~ls & (to_cnt == TW'(TIMEOUT - 1));
  assign line_mm  = ls & (state != SEARCH) & (h_inc != h_total);
  assign frame_mm = fs & (({h_inc, ha_new, v_inc, va_new} !=
                            {prev_ht, prev_ha, prev_vt, prev_va}) | ~sync_match);

  // Blank input samples for edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      hblnk_q <= hblnk_in;
      vblnk_q <= vblnk_in;
    end
  end

  // Recovered counters, geometry measurements and frame_start pulse
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount <= ls ? 12'd0 : h_inc;
      if (fs)      vcount   <= 12'd0;
      else if (ls) vcount   <= v_inc;
      if (ls)      h_total  <= h_inc;
      if (hb_rise) h_active <= h_inc;
      if (fs)      v_total  <= v_inc;
      if (vb_rise) v_active <= v_inc;
      frame_start <= fs;
    end
  end

  // Frame signature latched at every frame start
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prev_ht <= '0;
      prev_ha <= '0;
      prev_vt <= '0;
      prev_va <= '0;
    end else if (fs) begin
      prev_ht <= h_inc;
      prev_ha <= ha_new;
      prev_vt <= v_inc;
      prev_va <= va_new;
    end
  end

`ifdef VGA_DECODER_SYNC_CHECK_EN
  logic        hsync_q, vsync_q;
  logic [11:0] hs_cnt, vs_cnt, hsw_new, vsw_new, prev_hsw, prev_vsw;

  assign hsw_new    = (hsync_q & ~hsync_in) ? hs_cnt : h_sync_w;
  assign vsw_new    = (vsync_q & ~vsync_in) ? vs_cnt : v_sync_w;
  assign sync_match = (hsw_new == prev_hsw) && (vsw_new == prev_vsw);

  // Sync width counters: pixels while hsync high, lines while vsync high
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hs_cnt   <= '0;
      vs_cnt   <= '0;
      h_sync_w <= '0;
      v_sync_w <= '0;
      prev_hsw <= '0;
      prev_vsw <= '0;
    end else begin
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
      if (~hsync_q & hsync_in)   hs_cnt <= 12'd1;
      else if (hsync_in)         hs_cnt <= hs_cnt + 12'd1;
      if (~vsync_q & vsync_in)   vs_cnt <= 12'd1;
      else if (vsync_in & ls)    vs_cnt <= vs_cnt + 12'd1;
      h_sync_w <= hsw_new;
      v_sync_w <= vsw_new;
      if (fs) begin
        prev_hsw <= hsw_new;
        prev_vsw <= vsw_new;
      end
    end
  end
`else
  logic sync_unused;
  assign sync_unused = hsync_in ^ vsync_in;
  assign sync_match  = 1'b1;
  assign h_sync_w    = '0;
  assign v_sync_w    = '0;
`endif

  // Cycles since the last line start, saturating
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (ls)                     to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + TW'(1);
  end

  // FSM state, match counter and registered lock_err pulse
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      lock_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      lock_err  <= lock_err_nx;
    end
  end

  // Next state: timeout beats mismatch beats match
  always_comb begin
    state_nx = state;
    match_nx = match_cnt;
    if (timeout) begin
      state_nx = SEARCH;
      match_nx = '0;
    end else begin
      unique case (state)
        SEARCH: if (fs) begin
          state_nx = TRACK;
          match_nx = '0;
        end
        TRACK: begin
          if (line_mm || frame_mm) begin
            match_nx = '0;
          end else if (fs) begin
            match_nx = match_cnt + 4'd1;
            if (match_cnt + 4'd1 >= 4'(MATCH_FRAMES)) state_nx = LOCKED;
          end
        end
        LOCKED: if (line_mm || frame_mm) begin
          state_nx = TRACK;
          match_nx = '0;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Outputs from state
  always_comb begin
    locked      = (state == LOCKED);
    lock_err_nx = (state == LOCKED) && (state_nx != LOCKED);
  end
endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: takes hsync/vsync/hblnk/vblnk (active-high) and recovers hcount/vcount.
- Measures line/frame geometry and declares lock after consecutive identical frames.
- Sits behind any sync source (generator output, loopback, external capture) for self-check and for downstream pixel logic.

Parameters:
- MATCH_FRAMES, 2, consecutive identical frame measurements required for lock (1..15).
- TIMEOUT, 4096, cycles without a line start before returning to SEARCH.

Ports:
- clk_in  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing inputs, active-high, synchronous to clk_in.
- hcount, vcount  out  12 each  recovered counters.
- h_total, v_total  out  12 each  last measured pixels/line and lines/frame.
- h_active, v_active  out  12 each  last measured visible pixels and lines.
- h_sync_w  out  12  hsync width in pixels (see Optional Feature).
- v_sync_w  out  12  vsync width in lines (see Optional Feature).
- frame_start  out  1  one-cycle pulse at each recovered (0,0).
- locked  out  1  geometry stable.
- lock_err  out  1  one-cycle pulse when lock is lost.

Behaviour:
- Reset (async, rst_n=0): every output is 0; state SEARCH; match counter 0; all previous-sample registers 0.
- Edges: each input is registered once (x_q). Rise = ~x_q & x. Fall = x_q & ~x. Line start (LS) = hblnk fall. Frame start (FS) = vblnk fall, only when it coincides with LS.
- hcount:
  - On LS, hcount <= 0.
  - Otherwise hcount <= hcount+1, wrapping 4095->0.
  - Latency: with a conforming source, hcount at cycle t+1 equals the source hcount at t.
- vcount:
  - On FS, vcount <= 0.
  - Else on LS, vcount <= vcount+1 (12-bit wrap).
  - Otherwise vcount holds.
- Measurements, all registered:
  - On LS: h_total <= hcount+1.
  - On hblnk rise: h_active <= hcount+1.
  - On FS: v_total <= vcount+1.
  - On vblnk rise: v_active <= vcount+1.
  - When several fire in the same cycle, each updates independently.
- Per-line check: on LS in TRACK/LOCKED, if hcount+1 != stored h_total, a mismatch is flagged.
- Frame check: on FS, the new {h_total, h_active, v_total, v_active} is compared to the values latched at the previous FS.
- Timeout counter: cleared on LS, saturates at TIMEOUT.
- FSM:
  - SEARCH: wait for FS. On FS -> TRACK, match counter 0.
  - TRACK:
    - FS with frame match: match counter +1. When it reaches MATCH_FRAMES -> LOCKED, locked=1 from the next cycle.
    - FS with frame mismatch, or line mismatch: match counter 0, stay in TRACK.
  - LOCKED:
    - Any line or frame mismatch -> TRACK, locked=0, lock_err=1 for one cycle.
  - Any state: timeout reaching TIMEOUT -> SEARCH, locked=0. lock_err pulses only if the state was LOCKED.
  - Precedence within one cycle: timeout over mismatch over match.
- frame_start: asserted the cycle after FS, in every state.
- Reset mid-frame: counters and measurements clear immediately; relock requires the full sequence again.

Optional Feature:
- Macro: VGA_DECODER_SYNC_CHECK_EN.
- Defined:
  - hsync high-cycle counter; h_sync_w latched on hsync fall.
  - vsync line counter counts LS cycles (and the rise cycle) while vsync is high; v_sync_w latched on vsync fall.
  - Both widths are included in the frame comparison for lock.
- Undefined: h_sync_w and v_sync_w are tied to 0 and excluded from lock criteria. No sync counters are synthesised.

Test Plan:
- Reset, then drive the team generator (1344x806, active 1024x768, hsync 136, vsync 6) -> after the 1st FS: v_total=806, h_total=1344, h_active=1024, v_active=768. locked rises after FS #3 (MATCH_FRAMES=2). hcount/vcount equal the generator's values delayed by one cycle.
- Locked source; lengthen one line to 1345 -> lock_err pulses at that line's end, locked=0; relock after 2 further clean frames.
- Hold hblnk_in=0 for 5000 cycles while locked -> state SEARCH, locked=0, a single lock_err pulse; restoring the stream relocks after 3 FS.
- Assert rst_n=0 asynchronously mid-line (hcount~500) -> all outputs 0 without a clock edge; after release, lock sequence restarts.
- With VGA_DECODER_SYNC_CHECK_EN: h_sync_w=136, v_sync_w=6. Shorten vsync to 5 lines -> lock lost. Without the macro: widths read 0 and the same change keeps lock.
